rep_cmp_ctrl: RTL and testbench



---
 rtl/rep_cmp_ctrl.sv | 143 ++++++++++++++
 tb/tb_rep_cmp_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rep_cmp_ctrl.sv
// Execute-stage sequencer for CMPS/SCAS with optional REPE/REPNE prefix.
// Consumes comparator results, counts down the repeat count and reports ZF/CF/count on completion.
module rep_cmp_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       rep_mode,
  input  logic [CNT_W-1:0] count_in,
  input  logic             flush,
  input  logic             elem_valid,
  output logic             elem_ready,
  input  logic             agb,
  input  logic             eq,
  input  logic             bga,
  output logic             busy,
  output logic             done,
  output logic             zf,
  output logic             cf,
  output logic [CNT_W-1:0] count_out,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] ModeSingle = 2'b00;
  localparam logic [1:0] ModeRepe   = 2'b01;
  localparam logic [1:0] ModeRepne  = 2'b10;

  state_e           r_state;
  state_e           w_state_next;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic             r_zf;
  logic             r_cf;
  logic [CNT_W-1:0] r_count_out;
  logic             r_err;

  logic [1:0]       w_mode_in;
  logic             w_rep_in;
  logic             w_zero_rep;
  logic             w_onehot;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_term;
  logic             w_accept;

  // Encoding 11 is folded into single-compare mode at latch time.
  assign w_mode_in  = (rep_mode == 2'b11) ? ModeSingle : rep_mode;
  assign w_rep_in   = (w_mode_in != ModeSingle);
  assign w_zero_rep = w_rep_in && (count_in == '0);

  // Odd parity excludes 0 and 2 set bits; the AND term excludes all three set.
  assign w_onehot  = (agb ^ eq ^ bga) & ~(agb & eq & bga);
  assign w_cnt_dec = r_cnt - CNT_W'(1);
  assign w_accept  = elem_valid & elem_ready;

  assign w_term = ~w_onehot
                | (r_mode == ModeSingle)
                | (w_cnt_dec == '0)
                | ((r_mode == ModeRepe) & ~eq)
                | ((r_mode == ModeRepne) & eq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = w_zero_rep ? StDone : StRun;
        end
      end
      StRun: begin
        if (flush) begin
          w_state_next = StIdle;
        end else if (w_accept && w_term) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_comb begin
    busy       = (r_state != StIdle);
    done       = (r_state == StDone) && !flush;
    elem_ready = (r_state == StRun) && !flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode      <= ModeSingle;
      r_cnt       <= '0;
      r_zf        <= 1'b0;
      r_cf        <= 1'b0;
      r_count_out <= '0;
      r_err       <= 1'b0;
    end else begin
      if ((r_state == StIdle) && start) begin
        r_mode <= w_mode_in;
        r_cnt  <= count_in;
        if (w_zero_rep) begin
          r_count_out <= '0;
        end
      end
      if (w_accept) begin
        if (!w_onehot) begin
          r_err <= 1'b1;
          r_zf  <= 1'b0;
          r_cf  <= 1'b0;
        end else begin
          r_zf <= eq;
          r_cf <= bga;
        end
        // Single mode reports the untouched count; rep modes report the decremented one.
        if (r_mode == ModeSingle) begin
          r_count_out <= r_cnt;
        end else begin
          r_cnt       <= w_cnt_dec;
          r_count_out <= w_cnt_dec;
        end
      end
    end
  end

  assign zf        = r_zf;
  assign cf        = r_cf;
  assign count_out = r_count_out;
  assign err       = r_err;

endmodule

// File: tb/tb_rep_cmp_ctrl.sv
// Self-checking bench for rep_cmp_ctrl: directed scenarios plus randomized instructions
// checked against a per-instruction behavioural model of the compare/repeat rules.
module tb_rep_cmp_ctrl;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       rep_mode;
  logic [CNT_W-1:0] count_in;
  logic             flush;
  logic             elem_valid;
  logic             elem_ready;
  logic             agb, eq, bga;
  logic             busy, done, zf, cf, err;
  logic [CNT_W-1:0] count_out;

  int checks   = 0;
  int failures = 0;

  logic             m_zf, m_cf, m_err;
  logic [CNT_W-1:0] m_cnt_out;
  logic [2:0]       elem_q[$];

  rep_cmp_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rep_mode   (rep_mode),
    .count_in   (count_in),
    .flush      (flush),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .agb        (agb),
    .eq         (eq),
    .bga        (bga),
    .busy       (busy),
    .done       (done),
    .zf         (zf),
    .cf         (cf),
    .count_out  (count_out),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_elem(input logic v, input logic [2:0] t);
    elem_valid = v;
    {agb, eq, bga} = t;
  endtask

  function automatic logic [2:0] rand_elem(input logic [1:0] em, input int idx);
    int r;
    r = $urandom_range(0, 99);
    if (idx >= 40) return (em == 2'b01) ? 3'b100 : 3'b010;
    if (r < 5) begin
      case ($urandom_range(0, 4))
        0:       return 3'b000;
        1:       return 3'b110;
        2:       return 3'b011;
        3:       return 3'b101;
        default: return 3'b111;
      endcase
    end
    if ((em == 2'b01 && r < 80) || (em == 2'b10 && r < 20)) return 3'b010;
    return ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b001;
  endfunction

  // Runs one instruction end to end, consuming elem_q first and random elements after.
  task automatic do_inst(input logic [1:0] mode, input logic [CNT_W-1:0] cnt, input bit gaps,
                         input bit done_start);
    logic [1:0]       em;
    logic [CNT_W-1:0] remaining;
    logic [2:0]       t;
    bit               fin, mal;
    int               idx;
    em = (mode == 2'b11) ? 2'b00 : mode;
    rep_mode = mode;
    count_in = cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    rep_mode = 2'($urandom);
    count_in = $urandom;
    if (em != 2'b00 && cnt == '0) begin
      m_cnt_out = '0;
      checks++;
      if ({busy, done, elem_ready} !== 3'b110) begin
        failures++;
        $display("FAIL zero_count_handshake: busy/done/ready=%b required 110",
                 {busy, done, elem_ready});
      end
      checks++;
      if ({zf, cf, count_out} !== {m_zf, m_cf, m_cnt_out}) begin
        failures++;
        $display("FAIL zero_count_result: zf=%b cf=%b cnt=%0d required zf=%b cf=%b cnt=%0d",
                 zf, cf, count_out, m_zf, m_cf, m_cnt_out);
      end
    end else begin
      remaining = cnt;
      fin = 0;
      idx = 0;
      checks++;
      if ({busy, elem_ready, done} !== 3'b110) begin
        failures++;
        $display("FAIL run_entry: busy/ready/done=%b required 110", {busy, elem_ready, done});
      end
      while (!fin) begin
        if (gaps && $urandom_range(0, 2) == 0) begin
          set_elem(1'b0, 3'($urandom));
          tick;
          checks++;
          if ({busy, elem_ready, done, zf, cf, count_out, err} !==
              {3'b110, m_zf, m_cf, m_cnt_out, m_err}) begin
            failures++;
            $display("FAIL gap_hold: busy/ready/done=%b zf=%b cf=%b cnt=%0d required 110 %b %b %0d",
                     {busy, elem_ready, done}, zf, cf, count_out, m_zf, m_cf, m_cnt_out);
          end
          continue;
        end
        if (elem_q.size() > 0) t = elem_q.pop_front();
        else t = rand_elem(em, idx);
        set_elem(1'b1, t);
        tick;
        set_elem(1'b0, 3'b000);
        idx++;
        mal = !(t == 3'b100 || t == 3'b010 || t == 3'b001);
        if (mal) begin
          m_err = 1'b1;
          m_zf  = 1'b0;
          m_cf  = 1'b0;
        end else begin
          m_zf = t[1];
          m_cf = t[0];
        end
        if (em == 2'b00) begin
          m_cnt_out = cnt;
          fin = 1;
        end else begin
          remaining = remaining - 1;
          m_cnt_out = remaining;
          fin = (remaining == '0) || (em == 2'b01 && !t[1]) || (em == 2'b10 && t[1]);
        end
        if (mal) fin = 1;
        checks++;
        if ({done, busy} !== {fin, 1'b1}) begin
          failures++;
          $display("FAIL accept_done: elem %0d done/busy=%b required %b1", idx,
                   {done, busy}, fin);
        end
        checks++;
        if ({zf, cf, count_out, err} !== {m_zf, m_cf, m_cnt_out, m_err}) begin
          failures++;
          $display("FAIL accept_result: elem %0d zf=%b cf=%b cnt=%0d err=%b required %b %b %0d %b",
                   idx, zf, cf, count_out, err, m_zf, m_cf, m_cnt_out, m_err);
        end
      end
    end
    if (done_start) begin
      start = 1'b1;
      rep_mode = 2'b00;
    end
    tick;
    start = 1'b0;
    checks++;
    if ({busy, done, elem_ready} !== 3'b000) begin
      failures++;
      $display("FAIL back_to_idle: busy/done/ready=%b required 000", {busy, done, elem_ready});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, elem_ready, zf, cf, err, count_out} !== {6'b0, {CNT_W{1'b0}}}) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b ready=%b zf=%b cf=%b err=%b cnt=%0d required 0",
               busy, done, elem_ready, zf, cf, err, count_out);
    end
    m_zf = 0;
    m_cf = 0;
    m_err = 0;
    m_cnt_out = '0;
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single;
    elem_q = '{3'b010};
    do_inst(2'b00, 32'd5, 0, 0);
  endtask

  task automatic test_rep_zero;
    do_inst(2'b01, 32'd0, 0, 0);
  endtask

  task automatic test_repe;
    elem_q = '{3'b010, 3'b010, 3'b001};
    do_inst(2'b01, 32'd4, 0, 0);
  endtask

  task automatic test_repne_gaps;
    elem_q = '{3'b100, 3'b100, 3'b100};
    do_inst(2'b10, 32'd3, 1, 0);
  endtask

  task automatic test_boundary;
    elem_q = '{3'b010, 3'b100};
    do_inst(2'b01, {CNT_W{1'b1}}, 0, 1);
    elem_q = '{3'b100};
    do_inst(2'b10, 32'd1, 0, 0);
    elem_q = '{3'b001};
    do_inst(2'b11, 32'd7, 0, 0);
  endtask

  task automatic test_flush_reset;
    rep_mode = 2'b01;
    count_in = 32'd10;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (2) begin
      set_elem(1'b1, 3'b010);
      tick;
    end
    m_zf = 1;
    m_cf = 0;
    m_cnt_out = 32'd8;
    set_elem(1'b1, 3'b010);
    flush = 1'b1;
    #1;
    checks++;
    if ({done, elem_ready} !== 2'b00) begin
      failures++;
      $display("FAIL flush_run_comb: done/ready=%b required 00", {done, elem_ready});
    end
    tick;
    flush = 1'b0;
    set_elem(1'b0, 3'b000);
    checks++;
    if ({busy, done, zf, cf, count_out} !== {2'b00, m_zf, m_cf, m_cnt_out}) begin
      failures++;
      $display("FAIL flush_run: busy/done=%b zf=%b cf=%b cnt=%0d required 00 %b %b %0d",
               {busy, done}, zf, cf, count_out, m_zf, m_cf, m_cnt_out);
    end
    // Flush landing on the DONE cycle must swallow the pulse.
    rep_mode = 2'b00;
    count_in = 32'd9;
    start = 1'b1;
    tick;
    start = 1'b0;
    set_elem(1'b1, 3'b001);
    tick;
    set_elem(1'b0, 3'b000);
    m_zf = 0;
    m_cf = 1;
    m_cnt_out = 32'd9;
    flush = 1'b1;
    #1;
    checks++;
    if ({busy, done} !== 2'b10) begin
      failures++;
      $display("FAIL flush_done_comb: busy/done=%b required 10", {busy, done});
    end
    tick;
    flush = 1'b0;
    checks++;
    if ({busy, done, zf, cf, count_out} !== {2'b00, m_zf, m_cf, m_cnt_out}) begin
      failures++;
      $display("FAIL flush_done: busy/done=%b zf=%b cf=%b cnt=%0d required 00 %b %b %0d",
               {busy, done}, zf, cf, count_out, m_zf, m_cf, m_cnt_out);
    end
    rep_mode = 2'b01;
    count_in = 32'd10;
    start = 1'b1;
    tick;
    start = 1'b0;
    set_elem(1'b1, 3'b010);
    tick;
    set_elem(1'b0, 3'b000);
    checks++;
    if (count_out !== 32'd9) begin
      failures++;
      $display("FAIL pre_reset_count: cnt=%0d required 9", count_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, elem_ready, zf, cf, err, count_out} !== {6'b0, {CNT_W{1'b0}}}) begin
      failures++;
      $display("FAIL reset_mid_run: busy=%b done=%b ready=%b zf=%b cf=%b err=%b cnt=%0d required 0",
               busy, done, elem_ready, zf, cf, err, count_out);
    end
    m_zf = 0;
    m_cf = 0;
    m_err = 0;
    m_cnt_out = '0;
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_malformed;
    elem_q = '{3'b110};
    do_inst(2'b10, 32'd6, 0, 0);
    elem_q = '{3'b010};
    do_inst(2'b00, 32'd2, 0, 0);
  endtask

  task automatic test_random;
    logic [CNT_W-1:0] c;
    for (int i = 0; i < 60; i++) begin
      elem_q.delete();
      case ($urandom_range(0, 7))
        0:       c = '0;
        1:       c = {CNT_W{1'b1}};
        default: c = CNT_W'($urandom_range(1, 12));
      endcase
      do_inst(2'($urandom), c, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rep_mode = 2'b00;
    count_in = '0;
    flush = 1'b0;
    set_elem(1'b0, 3'b000);
    test_reset;
    test_single;
    test_rep_zero;
    test_repe;
    test_repne_gaps;
    test_boundary;
    test_flush_reset;
    test_random;
    test_malformed;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
